// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path:
// FSM states, opcodes, immediate-format selects and ALU op codes.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Immediate formats, shared with immGen
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic opc_supported(input logic [6:0] opc);
        return (opc == OPC_LOAD)   || (opc == OPC_OPIMM) ||
               (opc == OPC_STORE)  || (opc == OPC_BRANCH) ||
               (opc == OPC_OP);
    endfunction

    function automatic logic [1:0] imm_sel_of(input logic [6:0] opc);
        if (opc == OPC_STORE)
            return IMM_S;
        else if (opc == OPC_BRANCH)
            return IMM_B;
        else
            return IMM_I;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-not-ready cycles and flags the cycle
// on which one more stall would exhaust the WAIT_MAX budget.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] count;

    // Stall counter: clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    // This stall is the WAIT_MAX-th in a row; a ready in this
    // same cycle keeps en low, so completion beats the timeout.
    assign expired = en && (count == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with a
// sticky TRAP on bad opcodes or memory that never becomes ready.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        memReady,
    input  logic        brTaken,
    output logic [1:0]  immSel,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        pcSrc,
    output logic        memReq,
    output logic        memWe,
    output logic        memAddrSel,
    output logic        regWrite,
    output logic        wbSel,
    output logic        aluSrcB,
    output logic [1:0]  aluOp,
    output logic        fault,
    output logic [2:0]  state
);

    state_t     cur;
    logic [6:0] opcode;
    logic       wait_st;
    logic       expired;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign unused_instr = ^instr[31:7];
    assign state        = cur;
    assign immSel       = imm_sel_of(opcode);

    // Only FETCH and MEM wait on memory; leaving or completing clears
    assign wait_st = (cur == S_FETCH) || (cur == S_MEM);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!wait_st || memReady),
        .en      (wait_st && !memReady),
        .expired (expired)
    );

    // State sequencing and sticky fault
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur   <= S_FETCH;
            fault <= 1'b0;
        end else begin
            unique case (cur)
                S_FETCH: begin
                    if (memReady) begin
                        cur <= S_DECODE;
                    end else if (expired) begin
                        cur   <= S_TRAP;
                        fault <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (opc_supported(opcode)) begin
                        cur <= S_EXEC;
                    end else begin
                        cur   <= S_TRAP;
                        fault <= 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_OP, OPC_OPIMM:   cur <= S_WB;
                        OPC_LOAD, OPC_STORE: cur <= S_MEM;
                        OPC_BRANCH:          cur <= S_FETCH;
                        default: begin
                            cur   <= S_TRAP;
                            fault <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (memReady) begin
                        cur <= (opcode == OPC_LOAD) ? S_WB : S_FETCH;
                    end else if (expired) begin
                        cur   <= S_TRAP;
                        fault <= 1'b1;
                    end
                end
                S_WB: begin
                    cur <= S_FETCH;
                end
                S_TRAP: begin
                    cur <= S_TRAP;
                end
                default: begin
                    cur   <= S_TRAP;
                    fault <= 1'b1;
                end
            endcase
        end
    end

    // Datapath controls decoded from state; forced idle under reset
    always_comb begin
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        memReq     = 1'b0;
        memWe      = 1'b0;
        memAddrSel = 1'b0;
        regWrite   = 1'b0;
        wbSel      = 1'b0;
        aluSrcB    = 1'b0;
        aluOp      = ALU_ADD;
        if (!rst) begin
            unique case (cur)
                S_FETCH: begin
                    memReq  = 1'b1;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_OP: begin
                            aluOp = ALU_FUNCT;
                        end
                        OPC_OPIMM: begin
                            aluSrcB = 1'b1;
                            aluOp   = ALU_FUNCT;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            aluSrcB = 1'b1;
                        end
                        OPC_BRANCH: begin
                            aluOp   = ALU_CMP;
                            pcWrite = brTaken;
                            pcSrc   = brTaken;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MEM: begin
                    memReq     = 1'b1;
                    memAddrSel = 1'b1;
                    memWe      = (opcode == OPC_STORE);
                end
                S_WB: begin
                    regWrite = 1'b1;
                    wbSel    = (opcode == OPC_LOAD);
                end
                S_DECODE, S_TRAP: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors
// for each instruction class, timeout, trap and reset behaviour.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        memReady;
    logic        brTaken;
    logic [1:0]  immSel;
    logic        irWrite;
    logic        pcWrite;
    logic        pcSrc;
    logic        memReq;
    logic        memWe;
    logic        memAddrSel;
    logic        regWrite;
    logic        wbSel;
    logic        aluSrcB;
    logic [1:0]  aluOp;
    logic        fault;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] SW   = 32'h00112023;
    localparam logic [31:0] BAD  = 32'h0000007F;

    // enable bits: ir pcw pcs | mrq mwe mas | rw wbs asb
    localparam logic [8:0] E_NONE  = 9'b000_000_000;
    localparam logic [8:0] E_FRDY  = 9'b110_100_000;
    localparam logic [8:0] E_FWAIT = 9'b000_100_000;
    localparam logic [8:0] E_ASB   = 9'b000_000_001;
    localparam logic [8:0] E_MLD   = 9'b000_101_000;
    localparam logic [8:0] E_MST   = 9'b000_111_000;
    localparam logic [8:0] E_WBA   = 9'b000_000_100;
    localparam logic [8:0] E_WBL   = 9'b000_000_110;
    localparam logic [8:0] E_BRT   = 9'b011_000_000;

    multicycle_ctrl #(
        .WAIT_MAX (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .memReady   (memReady),
        .brTaken    (brTaken),
        .immSel     (immSel),
        .irWrite    (irWrite),
        .pcWrite    (pcWrite),
        .pcSrc      (pcSrc),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddrSel (memAddrSel),
        .regWrite   (regWrite),
        .wbSel      (wbSel),
        .aluSrcB    (aluSrcB),
        .aluOp      (aluOp),
        .fault      (fault),
        .state      (state)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [2:0] st,
                                       input logic [8:0] en,
                                       input logic [1:0] aop,
                                       input logic [1:0] isel,
                                       input logic       flt);
        return {st, en, aop, isel, flt};
    endfunction

    function automatic logic [16:0] obs();
        return {state, irWrite, pcWrite, pcSrc, memReq, memWe,
                memAddrSel, regWrite, wbSel, aluSrcB, aluOp,
                immSel, fault};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        memReady = 1'b0;
        brTaken  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] ex[3];
        ex = '{mk(0, E_NONE, 0, 0, 0),
               mk(0, E_NONE, 0, 1, 0),
               mk(0, E_FRDY, 0, 1, 0)};
        rst = 1'b1; instr = 32'h0; memReady = 1'b0; brTaken = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (obs() !== ex[0]) begin
            n_err++;
            $display("FAIL reset_idle: got %h want %h", obs(), ex[0]);
        end
        instr = SW; memReady = 1'b1; brTaken = 1'b1; #1;
        n_cmp++;
        if (obs() !== ex[1]) begin
            n_err++;
            $display("FAIL reset_gated: got %h want %h", obs(), ex[1]);
        end
        @(negedge clk);
        rst = 1'b0; brTaken = 1'b0; #1;
        n_cmp++;
        if (obs() !== ex[2]) begin
            n_err++;
            $display("FAIL reset_first_fetch: got %h want %h", obs(), ex[2]);
        end
    endtask

    task automatic test_addi();
        logic [16:0] ex[5];
        logic        mr[5];
        ex = '{mk(0, E_FRDY, 0, 0, 0), mk(1, E_NONE, 0, 0, 0),
               mk(2, E_ASB, 2, 0, 0),  mk(4, E_WBA, 0, 0, 0),
               mk(0, E_FWAIT, 0, 0, 0)};
        mr = '{1, 1, 1, 1, 0};
        apply_reset();
        instr = ADDI;
        for (int i = 0; i < 5; i++) begin
            memReady = mr[i]; #1;
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_err++;
                $display("FAIL addi[%0d]: got %h want %h", i, obs(), ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] ex[8];
        logic        mr[8];
        ex = '{mk(0, E_FRDY, 0, 0, 0), mk(1, E_NONE, 0, 0, 0),
               mk(2, E_ASB, 0, 0, 0),  mk(3, E_MLD, 0, 0, 0),
               mk(3, E_MLD, 0, 0, 0),  mk(3, E_MLD, 0, 0, 0),
               mk(4, E_WBL, 0, 0, 0),  mk(0, E_FWAIT, 0, 0, 0)};
        mr = '{1, 1, 1, 0, 0, 1, 1, 0};
        apply_reset();
        instr = LW;
        for (int i = 0; i < 8; i++) begin
            memReady = mr[i]; #1;
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_err++;
                $display("FAIL lw[%0d]: got %h want %h", i, obs(), ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [16:0] ex[8];
        logic        mr[8];
        logic        br[8];
        ex = '{mk(0, E_FRDY, 0, 2, 0), mk(1, E_NONE, 0, 2, 0),
               mk(2, E_BRT, 1, 2, 0),  mk(0, E_FRDY, 0, 2, 0),
               mk(1, E_NONE, 0, 2, 0), mk(2, E_NONE, 1, 2, 0),
               mk(0, E_FWAIT, 0, 2, 0), mk(0, E_FWAIT, 0, 2, 0)};
        mr = '{1, 1, 1, 1, 1, 1, 0, 0};
        br = '{1, 1, 1, 0, 0, 0, 0, 1};
        apply_reset();
        instr = BEQ;
        for (int i = 0; i < 8; i++) begin
            memReady = mr[i]; brTaken = br[i]; #1;
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_err++;
                $display("FAIL beq[%0d]: got %h want %h", i, obs(), ex[i]);
            end
            @(negedge clk);
        end
        brTaken = 1'b0;
    endtask

    task automatic test_store();
        logic [16:0] ex[5];
        logic        mr[5];
        ex = '{mk(0, E_FRDY, 0, 1, 0), mk(1, E_NONE, 0, 1, 0),
               mk(2, E_ASB, 0, 1, 0),  mk(3, E_MST, 0, 1, 0),
               mk(0, E_FWAIT, 0, 1, 0)};
        mr = '{1, 1, 1, 1, 0};
        apply_reset();
        instr = SW;
        for (int i = 0; i < 5; i++) begin
            memReady = mr[i]; #1;
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_err++;
                $display("FAIL sw[%0d]: got %h want %h", i, obs(), ex[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_opcode();
        logic [16:0] ex[5];
        ex = '{mk(0, E_FRDY, 0, 0, 0), mk(1, E_NONE, 0, 0, 0),
               mk(5, E_NONE, 0, 0, 1), mk(5, E_NONE, 0, 0, 1),
               mk(5, E_NONE, 0, 0, 1)};
        apply_reset();
        instr = BAD;
        for (int i = 0; i < 5; i++) begin
            memReady = 1'b1; brTaken = 1'b1; #1;
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_err++;
                $display("FAIL trap[%0d]: got %h want %h", i, obs(), ex[i]);
            end
            @(negedge clk);
        end
        rst = 1'b1; brTaken = 1'b0; #1;
        n_cmp++;
        if ({state, fault} !== 4'b0000) begin
            n_err++;
            $display("FAIL trap_reset: got %h want 0", {state, fault});
        end
        @(negedge clk);
        rst = 1'b0; memReady = 1'b0; #1;
        n_cmp++;
        if (obs() !== mk(0, E_FWAIT, 0, 0, 0)) begin
            n_err++;
            $display("FAIL trap_refetch: got %h want %h", obs(),
                     mk(0, E_FWAIT, 0, 0, 0));
        end
    endtask

    task automatic test_fetch_timeout();
        logic [16:0] want;
        apply_reset();
        instr = ADDI;
        for (int i = 0; i < 17; i++) begin
            memReady = 1'b0; #1;
            want = (i < 15) ? mk(0, E_FWAIT, 0, 0, 0)
                            : mk(5, E_NONE, 0, 0, 1);
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL fetch_tmo[%0d]: got %h want %h", i, obs(), want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ready_at_limit();
        logic [16:0] want;
        apply_reset();
        instr = ADDI;
        for (int i = 0; i < 17; i++) begin
            memReady = (i == 14); #1;
            if (i < 14)       want = mk(0, E_FWAIT, 0, 0, 0);
            else if (i == 14) want = mk(0, E_FRDY, 0, 0, 0);
            else if (i == 15) want = mk(1, E_NONE, 0, 0, 0);
            else              want = mk(2, E_ASB, 2, 0, 0);
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL ready_limit[%0d]: got %h want %h", i, obs(), want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_timeout();
        logic [16:0] want;
        apply_reset();
        instr = LW;
        for (int i = 0; i < 20; i++) begin
            memReady = (i < 3); #1;
            if (i == 0)      want = mk(0, E_FRDY, 0, 0, 0);
            else if (i == 1) want = mk(1, E_NONE, 0, 0, 0);
            else if (i == 2) want = mk(2, E_ASB, 0, 0, 0);
            else if (i < 18) want = mk(3, E_MLD, 0, 0, 0);
            else             want = mk(5, E_NONE, 0, 0, 1);
            n_cmp++;
            if (obs() !== want) begin
                n_err++;
                $display("FAIL mem_tmo[%0d]: got %h want %h", i, obs(), want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_reset_in_mem();
        logic [16:0] ex[4];
        logic        mr[4];
        ex = '{mk(0, E_FRDY, 0, 1, 0), mk(1, E_NONE, 0, 1, 0),
               mk(2, E_ASB, 0, 1, 0),  mk(3, E_MST, 0, 1, 0)};
        mr = '{1, 1, 1, 0};
        apply_reset();
        instr = SW;
        for (int i = 0; i < 4; i++) begin
            memReady = mr[i]; #1;
            n_cmp++;
            if (obs() !== ex[i]) begin
                n_err++;
                $display("FAIL swrst[%0d]: got %h want %h", i, obs(), ex[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #2;
        rst = 1'b1; #1;
        n_cmp++;
        if (obs() !== mk(0, E_NONE, 0, 1, 0)) begin
            n_err++;
            $display("FAIL swrst_abort: got %h want %h", obs(),
                     mk(0, E_NONE, 0, 1, 0));
        end
        @(negedge clk);
        rst = 1'b0; #1;
        n_cmp++;
        if (obs() !== mk(0, E_FWAIT, 0, 1, 0)) begin
            n_err++;
            $display("FAIL swrst_refetch: got %h want %h", obs(),
                     mk(0, E_FWAIT, 0, 1, 0));
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw_wait();
        test_branch();
        test_store();
        test_bad_opcode();
        test_fetch_timeout();
        test_ready_at_limit();
        test_mem_timeout();
        test_sw_reset_in_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum consecutive memReady-low cycles tolerated in FETCH or MEM before fault.
REQ-002 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port instr, input, 32: current instruction register contents; opcode = instr[6:0].
REQ-005 Port memReady, input, 1: memory completes the current request this cycle.
REQ-006 Port brTaken, input, 1: ALU compare result for branches, valid in EXEC.
REQ-007 Port immSel, output, 2: immediate-format select to immGen: 00 I-type, 01 S-type, 10 B-type.
REQ-008 Port irWrite / pcWrite / pcSrc, output, 1 each: load IR, load PC, PC source (0 = PC+4, 1 = branch target).
REQ-009 Port memReq / memWe / memAddrSel, output, 1 each: memory request, write enable, address source (0 = PC, 1 = ALU result).
REQ-010 Port regWrite / wbSel / aluSrcB, output, 1 each: register-file write, writeback source (0 = ALU, 1 = memory), ALU B operand (0 = rs2, 1 = immediate).
REQ-011 Port aluOp, output, 2: 00 add, 01 compare/subtract, 10 funct-decoded.
REQ-012 Port fault, output, 1: sticky fault indicator.
REQ-013 Port state, output, 3: current state encoding, for debug.

Function
REQ-014 Six states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; state and fault registered; all other outputs combinational from state, instr and inputs.
REQ-015 Supported opcodes: LOAD 0000011, OP-IMM 0010011, STORE 0100011, BRANCH 1100011, OP 0110011; immSel = 01 for STORE, 10 for BRANCH, otherwise 00, at all times.
REQ-016 FETCH: memReq=1, memAddrSel=0; when memReady=1, assert irWrite=1 and pcWrite=1 with pcSrc=0 in the same cycle, then go to DECODE; otherwise remain in FETCH.
REQ-017 DECODE: no enables asserted; unsupported opcode -> TRAP, else -> EXEC.
REQ-018 EXEC: OP gives aluSrcB=0, aluOp=10, -> WB; OP-IMM gives aluSrcB=1, aluOp=10, -> WB; LOAD/STORE give aluSrcB=1, aluOp=00, -> MEM.
REQ-019 EXEC for BRANCH: aluSrcB=0, aluOp=01; if brTaken=1, assert pcWrite=1 with pcSrc=1; always -> FETCH.
REQ-020 MEM: memReq=1, memAddrSel=1, memWe=1 for STORE only; on memReady, LOAD -> WB and STORE -> FETCH; otherwise remain in MEM.
REQ-021 WB: regWrite=1, wbSel=1 for LOAD and 0 otherwise; -> FETCH.
REQ-022 Instruction latency (zero wait states): branch 3 cycles, OP/OP-IMM/STORE 4 cycles, LOAD 5 cycles; each memory wait cycle adds 1.
REQ-023 A wait counter clears on entry to FETCH or MEM and increments on each cycle with memReady=0; when it reaches WAIT_MAX with memReady still 0 -> TRAP.
REQ-024 If memReady=1 arrives in the same cycle the counter reaches WAIT_MAX, completion wins and there is no fault.
REQ-025 TRAP: fault=1; all enables and memReq are 0; the block remains in TRAP until reset.
REQ-026 memWe is never asserted without memReq; regWrite is asserted only in WB.

Reset
REQ-027 While rst=1: state=FETCH, fault=0, wait counter=0; all enables are driven 0 regardless of state logic.
REQ-028 Reset asserted mid-instruction abandons it, with no partial PC, register or memory write after reset deasserts.
REQ-029 The first cycle after reset deassertion is FETCH, with memReq=1.

Structure
REQ-030 Shared package riscv_ctrl_pkg holds the state encodings, opcode constants, immSel codes and aluOp codes; immGen uses the same immSel codes.
REQ-031 One sub-module, mem_wait_timer, implements the WAIT_MAX counter with clear/enable inputs and an expired output; all other logic stays in multicycle_ctrl.

Verification
REQ-032 ADDI 0x00500093, memReady=1 always -> states 0,1,2,4,0; aluSrcB=1 in EXEC; regWrite=1 exactly one cycle; immSel=00.
REQ-033 LW 0x0000A103, memReady low 2 cycles in MEM -> MEM lasts 3 cycles; wbSel=1 and regWrite=1 in WB; total 7 cycles.
REQ-034 BEQ 0x00208463: brTaken=1 -> pcWrite=1 with pcSrc=1 in EXEC, immSel=10; brTaken=0 -> no pcWrite in EXEC; both cases return to FETCH after 3 cycles.
REQ-035 Opcode 0x7F in IR -> TRAP after DECODE, fault=1, no enables afterwards; reset clears fault and state returns to 0.
REQ-036 WAIT_MAX=15, memReady held 0 in FETCH -> TRAP after 15 wait cycles; a separate run with memReady=1 on the 15th cycle -> DECODE and no fault.
REQ-037 SW 0x00112023 with rst asserted in MEM -> memWe drops to 0 immediately, state=0 and fault=0.
